// File: rtl/pj_pkg.sv
// Shared types and helpers for the MindFocus sequence engine.
package pj_pkg;

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    SORTEIA   = 4'd1,
    EXIBE_ON  = 4'd2,
    EXIBE_OFF = 4'd3,
    ESPERA    = 4'd4,
    COMPARA   = 4'd5,
    GANHOU    = 4'd6,
    PERDEU    = 4'd7
  } estado_t;

  localparam logic [15:0] LFSR_MASK      = 16'hB400;
  localparam logic [15:0] SEMENTE_PADRAO = 16'hACE1;

  function automatic int w_r(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Galois step, right shift; the mask is applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/pj_lfsr_galois.sv
// 16-bit Galois LFSR with seed load; a zero seed falls back to SEMENTE_PADRAO.
module pj_lfsr_galois
  import pj_pkg::*;
#(
  parameter logic [15:0] SEMENTE = SEMENTE_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  localparam logic [15:0] RESET_VAL = (SEMENTE == 16'h0000) ? SEMENTE_PADRAO : SEMENTE;

  logic [15:0] seed_ok;

  assign seed_ok = (seed == 16'h0000) ? SEMENTE_PADRAO : seed;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= seed_ok;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/pj_motor_sequencia.sv
// MindFocus sequence engine: draws, displays and checks a growing button sequence.
// PJ_SEMENTE_FIXA_EN: every game starts from SEMENTE; otherwise from a free-running counter.
module pj_motor_sequencia
  import pj_pkg::*;
#(
  parameter int          N_BOTOES = 4,
  parameter int          DEPTH    = 16,
  parameter int          T_EXIBE  = 50_000_000,
  parameter int          T_PAUSA  = 25_000_000,
  parameter int          T_LIMITE = 250_000_000,
  parameter logic [15:0] SEMENTE  = 16'hACE1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic [N_BOTOES-1:0]       botoes,
  output logic [N_BOTOES-1:0]       leds,
  output logic [w_r(DEPTH)-1:0]     rodada,
  output logic [w_r(DEPTH)-1:0]     pontos,
  output logic                      vez_jogador,
  output logic                      ganhou,
  output logic                      perdeu,
  output logic                      timeout,
  output logic [3:0]                db_estado
);

  // state     | meaning
  // OCIOSO    | idle after reset, waits for iniciar
  // SORTEIA   | draw one new element, append it to the sequence
  // EXIBE_ON  | LED of mem[ptr] lit for T_EXIBE cycles
  // EXIBE_OFF | dark gap of T_PAUSA cycles between elements
  // ESPERA    | wait for a press edge, T_LIMITE cycles max
  // COMPARA   | check the registered press against mem[ptr]
  // GANHOU    | all DEPTH rounds completed, waits for iniciar
  // PERDEU    | wrong press or timeout, waits for iniciar

  localparam int W_R = w_r(DEPTH);
  localparam int W_P = $clog2(DEPTH);
  localparam int W_I = $clog2(N_BOTOES);

  estado_t             estado, estado_nx;
  logic [31:0]         timer, timer_carga;
  logic [W_R-1:0]      ptr;
  logic [W_I-1:0]      mem [DEPTH];
  logic [N_BOTOES-1:0] jogada, alvo;
  logic                botao_ant;
  logic [15:0]         lfsr_val, lfsr_nx, semente_ini;
  logic [W_I-1:0]      sorteio;
  logic                inicio, aresta, fim_tempo, acerto, ultimo, completo;

`ifdef PJ_SEMENTE_FIXA_EN
  assign semente_ini = SEMENTE;
`else
  logic [15:0] contador;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contador <= 16'h0000;
    end else begin
      contador <= contador + 16'h0001;
    end
  end

  assign semente_ini = contador;
`endif

  pj_lfsr_galois #(.SEMENTE(SEMENTE)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (inicio),
    .seed  (semente_ini),
    .step  (estado == SORTEIA),
    .value (lfsr_val)
  );

  // The element drawn in SORTEIA comes from the value the LFSR steps into.
  assign lfsr_nx   = lfsr_next(lfsr_val);
  assign sorteio   = W_I'((lfsr_nx & 16'h00FF) % 16'(N_BOTOES));

  assign alvo      = N_BOTOES'(1) << mem[ptr[W_P-1:0]];
  assign inicio    = iniciar && (estado == OCIOSO || estado == GANHOU || estado == PERDEU);
  assign aresta    = (|botoes) && !botao_ant;
  assign fim_tempo = (timer == 32'd0);
  assign acerto    = (jogada == alvo);
  assign ultimo    = (ptr == rodada - W_R'(1));
  assign completo  = (rodada == W_R'(DEPTH));

  always_comb begin
    estado_nx   = estado;
    timer_carga = 32'd0;
    case (estado)
      OCIOSO, GANHOU, PERDEU: if (iniciar) estado_nx = SORTEIA;
      SORTEIA:                estado_nx = EXIBE_ON;
      EXIBE_ON:               if (fim_tempo) estado_nx = EXIBE_OFF;
      EXIBE_OFF:              if (fim_tempo) estado_nx = ultimo ? ESPERA : EXIBE_ON;
      ESPERA: begin
        if (aresta)         estado_nx = COMPARA;
        else if (fim_tempo) estado_nx = PERDEU;
      end
      COMPARA: begin
        if (!acerto)        estado_nx = PERDEU;
        else if (!ultimo)   estado_nx = ESPERA;
        else if (completo)  estado_nx = GANHOU;
        else                estado_nx = SORTEIA;
      end
      default:                estado_nx = OCIOSO;
    endcase
    case (estado_nx)
      EXIBE_ON:  timer_carga = 32'(T_EXIBE - 1);
      EXIBE_OFF: timer_carga = 32'(T_PAUSA - 1);
      ESPERA:    timer_carga = 32'(T_LIMITE - 1);
      default:   timer_carga = 32'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      timer     <= 32'd0;
      ptr       <= '0;
      rodada    <= '0;
      pontos    <= '0;
      ganhou    <= 1'b0;
      perdeu    <= 1'b0;
      timeout   <= 1'b0;
      jogada    <= '0;
      botao_ant <= 1'b0;
    end else begin
      estado    <= estado_nx;
      botao_ant <= |botoes;
      // Every state change restarts the shared down-counter.
      if (estado_nx != estado) begin
        timer <= timer_carga;
      end else if (!fim_tempo) begin
        timer <= timer - 32'd1;
      end
      case (estado)
        OCIOSO, GANHOU, PERDEU: begin
          if (iniciar) begin
            rodada  <= '0;
            pontos  <= '0;
            ptr     <= '0;
            ganhou  <= 1'b0;
            perdeu  <= 1'b0;
            timeout <= 1'b0;
          end
        end
        SORTEIA: begin
          rodada <= rodada + W_R'(1);
          ptr    <= '0;
        end
        EXIBE_OFF: if (fim_tempo) ptr <= ultimo ? '0 : ptr + W_R'(1);
        ESPERA: begin
          if (aresta) begin
            jogada <= botoes;
          end else if (fim_tempo) begin
            perdeu  <= 1'b1;
            timeout <= 1'b1;
          end
        end
        COMPARA: begin
          if (!acerto) begin
            perdeu <= 1'b1;
          end else if (!ultimo) begin
            ptr <= ptr + W_R'(1);
          end else begin
            pontos <= pontos + W_R'(1);
            if (completo) ganhou <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (estado == SORTEIA) mem[rodada[W_P-1:0]] <= sorteio;
  end

  // Decoded from the state register so an asynchronous reset blanks the LEDs at once.
  assign leds        = (estado == EXIBE_ON) ? alvo : '0;
  assign vez_jogador = (estado == ESPERA);
  assign db_estado   = estado;

endmodule

// File: tb/tb_pj_motor_sequencia.sv
// Randomized scoreboard bench for pj_motor_sequencia (short timers, DEPTH=3).
module tb_pj_motor_sequencia;

  localparam int N  = 4;
  localparam int D  = 3;
  localparam int TE = 4;
  localparam int TP = 2;
  localparam int TL = 20;
  localparam int WR = $clog2(D + 1);

  typedef struct {
    int g;
    int p;
    int t;
    int pts;
  } fim_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iniciar = 1'b0;
  logic [N-1:0]  botoes = '0;
  logic [N-1:0]  leds;
  logic [WR-1:0] rodada, pontos;
  logic          vez_jogador, ganhou, perdeu, timeout;
  logic [3:0]    db_estado;

  int   n_testes = 0;
  int   n_falhas = 0;
  int   c_esp = 0;
  logic [15:0] tb_cnt;
  int   exp_led[$];
  fim_t exp_fim[$];

  pj_motor_sequencia #(
    .N_BOTOES (N),
    .DEPTH    (D),
    .T_EXIBE  (TE),
    .T_PAUSA  (TP),
    .T_LIMITE (TL),
    .SEMENTE  (16'hACE1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .botoes      (botoes),
    .leds        (leds),
    .rodada      (rodada),
    .pontos      (pontos),
    .vez_jogador (vez_jogador),
    .ganhou      (ganhou),
    .perdeu      (perdeu),
    .timeout     (timeout),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  // Cycles since reset release: the seed source when no fixed seed is configured.
  always @(posedge clock or negedge reset) begin
    if (!reset) tb_cnt <= 16'h0000;
    else        tb_cnt <= tb_cnt + 16'h0001;
  end

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_testes++;
    if (got !== exp) begin
      n_falhas++;
      $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    end
  endtask

  function automatic logic [15:0] passo(input logic [15:0] v);
    logic [15:0] r;
    r = v / 2;
    if (v % 2 == 1) r = r ^ 16'hB400;
    return r;
  endfunction

  // Monitor: LED flashes and end-of-game events against the expected queues.
  int         lit_n = 0;
  int         dark_n = -1;
  logic [N-1:0] lit_val = '0;
  logic       fim_ant = 1'b0;
  fim_t       fm;

  always @(negedge clock) begin
    if (!reset) begin
      lit_n   = 0;
      dark_n  = -1;
      fim_ant = 1'b0;
    end else begin
      if (leds != '0) begin
        if (dark_n >= 0) begin
          check("pausa_ciclos", dark_n, TP);
          dark_n = -1;
        end
        if (lit_n == 0) lit_val = leds;
        lit_n++;
      end else if (lit_n != 0) begin
        if (exp_led.size() == 0) check("led_inesperado", lit_val, 0);
        else                     check("led_valor", lit_val, 1 << exp_led.pop_front());
        check("led_ciclos", lit_n, TE);
        lit_n  = 0;
        dark_n = 1;
      end else if (dark_n >= 0) begin
        if (vez_jogador) begin
          check("pausa_ciclos", dark_n, TP);
          dark_n = -1;
        end else begin
          dark_n++;
        end
      end
      if ((ganhou || perdeu) && !fim_ant) begin
        if (exp_fim.size() == 0) begin
          check("fim_inesperado", {ganhou, perdeu}, 0);
        end else begin
          fm = exp_fim.pop_front();
          check("fim_ganhou", ganhou, fm.g);
          check("fim_perdeu", perdeu, fm.p);
          check("fim_timeout", timeout, fm.t);
          check("fim_pontos", pontos, fm.pts);
        end
      end
      fim_ant = ganhou || perdeu;
    end
  end

  task automatic tick();
    @(negedge clock);
    if (vez_jogador) c_esp++;
    else             c_esp = 0;
  endtask

  task automatic espera_vez(input string nome);
    int n = 0;
    tick();
    while (!vez_jogador && n < 200) begin
      tick();
      n++;
    end
    check(nome, vez_jogador, 1);
  endtask

  task automatic espera_fim(input string nome);
    int n = 0;
    while (!(ganhou || perdeu) && n < 40) begin
      tick();
      n++;
    end
    check(nome, ganhou || perdeu, 1);
  endtask

  // Press at a random ESPERA cycle; a quarter of the presses land on the last allowed cycle.
  task automatic pressiona(input logic [N-1:0] val);
    int c_t;
    c_t = ($urandom_range(0, 3) == 0) ? TL : $urandom_range(c_esp, TL);
    while (c_esp < c_t && vez_jogador) tick();
    botoes = val;
    repeat ($urandom_range(1, 3)) tick();
    botoes = '0;
  endtask

  // modo 0: win, 1: wrong press at (r_f,k_f), 2: timeout at (r_f,k_f); multi selects a multi-button error.
  task automatic jogar(input int modo, input int r_f, input int k_f, input int multi);
    logic [15:0]  v;
    int           seq [D];
    int           outro, ult, n;
    logic [N-1:0] val;
    fim_t         f;
    tick();
`ifdef PJ_SEMENTE_FIXA_EN
    v = 16'hACE1;
`else
    v = tb_cnt;
`endif
    if (v == 16'h0000) v = 16'hACE1;
    for (int i = 0; i < D; i++) begin
      v = passo(v);
      seq[i] = (v % 256) % N;
    end
    exp_led.push_back(seq[0]);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("inicio_flags", {ganhou, perdeu, timeout}, 0);
    check("inicio_pontos", pontos, 0);
    tick();
    check("inicio_rodada", rodada, 1);
    check("inicio_led", leds, 1 << seq[0]);
    for (int r = 1; r <= D; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        n = 0;
        while (leds == '0 && n < 20) begin
          tick();
          n++;
        end
        botoes = N'($urandom_range(1, (1 << N) - 1));
        espera_vez("vez_distraido");
        repeat ($urandom_range(1, 2)) tick();
        botoes = '0;
        tick();
      end else begin
        espera_vez("vez_rodada");
      end
      check("rodada", rodada, r);
      check("pontos", pontos, r - 1);
      for (int k = 0; k < r; k++) begin
        if (k > 0) espera_vez("vez_elemento");
        if (modo == 2 && r == r_f && k == k_f) begin
          f = '{0, 1, 1, r - 1};
          exp_fim.push_back(f);
          n   = 0;
          ult = c_esp;
          while (!perdeu && n < 40) begin
            ult = c_esp;
            tick();
            n++;
          end
          check("timeout_ciclos", ult, TL);
          check("timeout_estado", db_estado, 7);
          return;
        end
        if (modo == 1 && r == r_f && k == k_f) begin
          outro = (seq[k] + 1 + $urandom_range(0, N - 2)) % N;
          val   = N'(1 << outro);
          if (multi != 0) val = val | N'(1 << seq[k]);
          f = '{0, 1, 0, r - 1};
          exp_fim.push_back(f);
          pressiona(val);
          espera_fim("erro_fim");
          check("erro_estado", db_estado, 7);
          return;
        end
        if (k == r - 1 && r < D) begin
          for (int i = 0; i <= r; i++) exp_led.push_back(seq[i]);
        end
        if (k == r - 1 && r == D) begin
          f = '{1, 0, 0, D};
          exp_fim.push_back(f);
        end
        pressiona(N'(1 << seq[k]));
      end
    end
    espera_fim("vitoria_fim");
    check("vitoria_estado", db_estado, 6);
    check("vitoria_rodada", rodada, D);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int modo, r, k, n;
    repeat (3) @(negedge clock);
    check("reset_leds", leds, 0);
    check("reset_rodada", rodada, 0);
    check("reset_pontos", pontos, 0);
    check("reset_flags", {ganhou, perdeu, timeout}, 0);
    check("reset_estado", db_estado, 0);
    check("reset_vez", vez_jogador, 0);
    #3 reset = 1'b1;

    jogar(0, 0, 0, 0);
    jogar(1, 2, 1, 1);
    jogar(2, 1, 0, 0);
    jogar(1, 3, 0, 0);
    jogar(2, 3, 2, 0);
    for (int g = 0; g < 8; g++) begin
      modo = $urandom_range(0, 2);
      r    = $urandom_range(1, D);
      k    = $urandom_range(0, r - 1);
      jogar(modo, r, k, $urandom_range(0, 1));
    end
    repeat (3) tick();
    check("fila_led_vazia", exp_led.size(), 0);
    check("fila_fim_vazia", exp_fim.size(), 0);

    // Asynchronous reset in the middle of a displayed element.
    tick();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    n = 0;
    while (leds == '0 && n < 10) begin
      tick();
      n++;
    end
    check("reset_meio_aceso", leds != '0, 1);
    #2 reset = 1'b0;
    #1;
    check("reset_meio_leds", leds, 0);
    check("reset_meio_rodada", rodada, 0);
    check("reset_meio_estado", db_estado, 0);
    exp_led.delete();
    tick();
    #3 reset = 1'b1;
    repeat (5) tick();
    check("pos_reset_estado", db_estado, 0);
    check("pos_reset_leds", leds, 0);
    check("pos_reset_rodada", rodada, 0);

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
